// File: rtl/cmd_sender.sv
// Sends each 16-bit command as two back-to-back 8N1 UART frames, high byte first.
// Latency: start bit on TX at the edge that accepts snd_cmd; 20*BAUD_DIV clocks per command.
// Backpressure: one-deep pending buffer; a request arriving while it is full is dropped with an overrun pulse.
module cmd_sender #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        buf_full,
    output logic        cmd_sent,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HIGH_BYTE = 2'd1,
        LOW_BYTE  = 2'd2
    } state_t;

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  BIT_LAST  = 4'd9;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [11:0] baud_cnt;
    // Frame shifter: {stop, data[7:0], start}; bit 0 is the line level.
    logic [9:0]  shreg;
    logic [7:0]  lo_byte;
    logic [15:0] buf_cmd;
    // Blocks a snd_cmd level that was held through reset from launching on the first edge.
    logic        rst_blank;

    logic        req;
    logic        bit_end;
    logic        frame_end;
    logic        cmd_done;
    logic [15:0] next_word;

    // TX comes straight off the shifter flop so the line never glitches.
    assign TX = shreg[0];

    // Decode request qualification and end-of-bit / end-of-command timing.
    always_comb begin
        req       = snd_cmd & ~rst_blank;
        bit_end   = (baud_cnt == BAUD_LAST);
        frame_end = bit_end && (bit_cnt == BIT_LAST);
        cmd_done  = (state == LOW_BYTE) && frame_end;
        // At the end of a command the buffered word has priority over a fresh request.
        next_word = buf_full ? buf_cmd : cmd;
    end

    // Framing state machine, bit timing, pending buffer and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            baud_cnt  <= 12'd0;
            shreg     <= '1;
            lo_byte   <= 8'd0;
            buf_cmd   <= 16'd0;
            buf_full  <= 1'b0;
            busy      <= 1'b0;
            cmd_sent  <= 1'b0;
            overrun   <= 1'b0;
            rst_blank <= 1'b1;
        end else begin
            rst_blank <= 1'b0;
            cmd_sent  <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= HIGH_BYTE;
                        busy     <= 1'b1;
                        shreg    <= {1'b1, cmd[15:8], 1'b0};
                        lo_byte  <= cmd[7:0];
                        bit_cnt  <= 4'd0;
                        baud_cnt <= 12'd0;
                    end
                end

                HIGH_BYTE, LOW_BYTE: begin
                    if (!bit_end) begin
                        baud_cnt <= baud_cnt + 12'd1;
                    end else begin
                        baud_cnt <= 12'd0;
                        if (bit_cnt != BIT_LAST) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= {1'b1, shreg[9:1]};
                        end else begin
                            bit_cnt <= 4'd0;
                            if (state == HIGH_BYTE) begin
                                // Low-byte start bit follows the high-byte stop bit directly.
                                state <= LOW_BYTE;
                                shreg <= {1'b1, lo_byte, 1'b0};
                            end else begin
                                cmd_sent <= 1'b1;
                                if (buf_full || req) begin
                                    state   <= HIGH_BYTE;
                                    shreg   <= {1'b1, next_word[15:8], 1'b0};
                                    lo_byte <= next_word[7:0];
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    shreg <= '1;
                                end
                            end
                        end
                    end

                    // Pending buffer: at the command boundary the buffer drains into the
                    // shifter and may be refilled by a same-cycle request without overrun.
                    if (cmd_done) begin
                        if (buf_full) begin
                            if (req) begin
                                buf_cmd <= cmd;
                            end else begin
                                buf_full <= 1'b0;
                            end
                        end
                    end else if (req) begin
                        if (buf_full) begin
                            overrun <= 1'b1;
                        end else begin
                            buf_cmd  <= cmd;
                            buf_full <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    shreg <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sender.sv
// Bench for cmd_sender: command-level reference model checked every cycle,
// plus directed scenarios with hand-computed line patterns and timings.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cmd_sender;

    localparam int B       = 16;
    localparam int CMD_CYC = 20 * B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'd0;
    logic        TX;
    logic        busy;
    logic        buf_full;
    logic        cmd_sent;
    logic        overrun;

    cmd_sender #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .TX       (TX),
        .busy     (busy),
        .buf_full (buf_full),
        .cmd_sent (cmd_sent),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_sent = 0;
    int n_ovr  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (command level) ----------------
    // A command is a 20-bit-slot line pattern; m_t is the clock index inside it.
    bit          m_active, m_buf_full, m_blank, m_sent, m_ovr;
    int          m_t;
    logic [15:0] m_cur, m_buf;

    function automatic logic frame_bit(input logic [15:0] w, input int k);
        if (k == 0 || k == 10) return 1'b0;
        if (k == 9 || k == 19) return 1'b1;
        if (k < 9) return w[7 + k];
        return w[k - 11];
    endfunction

    initial begin
        bit sn;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 0; m_buf_full = 0; m_blank = 1;
                m_sent = 0; m_ovr = 0; m_t = 0;
            end else begin
                sn = snd_cmd && !m_blank;
                m_blank = 0; m_sent = 0; m_ovr = 0;
                if (!m_active) begin
                    if (sn) begin m_active = 1; m_cur = cmd; m_t = 0; end
                end else if (m_t == CMD_CYC - 1) begin
                    m_sent = 1;
                    if (m_buf_full) begin
                        m_cur = m_buf; m_t = 0;
                        if (sn) m_buf = cmd; else m_buf_full = 0;
                    end else if (sn) begin
                        m_cur = cmd; m_t = 0;
                    end else begin
                        m_active = 0;
                    end
                end else begin
                    m_t++;
                    if (sn) begin
                        if (m_buf_full) m_ovr = 1;
                        else begin m_buf = cmd; m_buf_full = 1; end
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_tx", TX, 1);
                check("rst_busy", busy, 0);
                check("rst_buf_full", buf_full, 0);
                check("rst_cmd_sent", cmd_sent, 0);
                check("rst_overrun", overrun, 0);
            end else begin
                check("tx", TX, m_active ? frame_bit(m_cur, m_t / B) : 1'b1);
                check("busy", busy, m_active);
                check("buf_full", buf_full, m_buf_full);
                check("cmd_sent", cmd_sent, m_sent);
                check("overrun", overrun, m_ovr);
                if (cmd_sent === 1'b1) n_sent++;
                if (overrun === 1'b1) n_ovr++;
            end
        end
    end

    // ---------------- stimulus helpers (called on a falling edge) ----------------
    task automatic pulse(input logic [15:0] w);
        cmd = w;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", (n < limit), 1);
    endtask

    task automatic wait_model_t(input int target, input int limit);
        int n = 0;
        while (!(m_active && m_t == target) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("slot_timeout", (n < limit), 1);
    endtask

    // Launch w from idle, sample the middle of every bit slot, note when cmd_sent fires.
    task automatic send_capture(input logic [15:0] w, output logic [19:0] v, output int sent_at);
        v = '0;
        sent_at = -1;
        pulse(w);
        for (int k = 0; k <= CMD_CYC + 5; k++) begin
            if ((k % B) == B / 2 && k < CMD_CYC) v = {TX, v[19:1]};
            if (cmd_sent === 1'b1 && sent_at < 0) sent_at = k;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [19:0] v;
        int          sent_at;
        int          s0, o0;

        // Reset values, with snd_cmd held high through reset deassertion.
        cmd = 16'h1234;
        snd_cmd = 1'b1;
        wait_cycles(3);
        check("reset_tx", TX, 1);
        check("reset_busy", busy, 0);
        check("reset_buf_full", buf_full, 0);
        rst = 1'b0;
        @(negedge clk);
        snd_cmd = 1'b0;
        check("held_through_rst_busy", busy, 0);
        check("held_through_rst_tx", TX, 1);
        wait_cycles(4);
        check("held_through_rst_still_idle", busy, 0);

        // Single command A55A: line pattern, cmd_sent timing, busy falling.
        send_capture(16'hA55A, v, sent_at);
        check("a55a_pattern", v, 20'b1010110100_1101001010);
        check("a55a_sent_at", sent_at, 320);
        check("a55a_busy_after", busy, 0);
        check("a55a_tx_after", TX, 1);

        // Buffered second command starts on the first cmd_sent edge.
        s0 = n_sent;
        pulse(16'h00FF);
        wait_cycles(50);
        pulse(16'hFF00);
        check("buffered_buf_full", buf_full, 1);
        begin
            int n = 0;
            while (cmd_sent !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
            check("first_sent_timeout", (n < 1000), 1);
        end
        check("chain_busy", busy, 1);
        check("chain_tx_start", TX, 0);
        check("chain_buf_drained", buf_full, 0);
        wait_idle(1000);
        check("chain_sent_count", n_sent - s0, 2);

        // Third request while buffer full is dropped.
        s0 = n_sent;
        o0 = n_ovr;
        pulse(16'h1111);
        wait_cycles(10);
        pulse(16'h2222);
        wait_cycles(10);
        pulse(16'h3333);
        check("overrun_buf_still_full", buf_full, 1);
        wait_idle(1500);
        check("overrun_count", n_ovr - o0, 1);
        check("overrun_sent_count", n_sent - s0, 2);

        // Request in the final cycle with the buffer empty: direct launch.
        s0 = n_sent;
        o0 = n_ovr;
        pulse(16'h0F0F);
        wait_model_t(CMD_CYC - 1, 1000);
        pulse(16'hABCD);
        check("final_empty_sent", cmd_sent, 1);
        check("final_empty_busy", busy, 1);
        check("final_empty_tx", TX, 0);
        check("final_empty_buf", buf_full, 0);

        // Request in the final cycle with the buffer full: buffer drains and refills.
        wait_cycles(30);
        pulse(16'h1357);
        check("final_full_pre_buf", buf_full, 1);
        wait_model_t(CMD_CYC - 1, 1000);
        pulse(16'h2468);
        check("final_full_sent", cmd_sent, 1);
        check("final_full_buf", buf_full, 1);
        check("final_full_overrun", overrun, 0);
        check("final_full_tx", TX, 0);
        wait_idle(2000);
        check("final_sent_count", n_sent - s0, 4);
        check("final_overrun_count", n_ovr - o0, 0);

        // Reset during the high byte with a buffered command, then a clean send.
        pulse(16'hC3C3);
        wait_cycles(20);
        pulse(16'h7777);
        wait_cycles(40);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", TX, 1);
        check("abort_busy", busy, 0);
        check("abort_buf_full", buf_full, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(2);
        check("abort_stays_idle", busy, 0);
        send_capture(16'h0001, v, sent_at);
        check("post_abort_pattern", v, 20'b1000000010_1000000000);
        check("post_abort_sent_at", sent_at, 320);
        check("post_abort_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t required < 2000000", $time);
        $fatal(1);
    end

endmodule

// File: doc/cmd_sender.md
CMD_SENDER -- requirements
Module: cmd_sender

Interface
REQ-001 Parameter: BAUD_DIV, default 2604, clocks per UART bit time (19200 baud at 50 MHz); legal range 4..4095.
REQ-002 Ports: clk  input  1  system clock; single clock domain. Reset is asynchronous and active-high.
REQ-003 Ports: rst  input  1  asynchronous active-high reset.
REQ-004 Ports: cmd  input  16  command word; sampled only on an accepted snd_cmd.
REQ-005 Ports: snd_cmd  input  1  one-cycle request to send cmd.
REQ-006 Ports: TX  output  1  8N1 serial line, idles high.
REQ-007 Ports: busy  output  1  high while any frame is in progress.
REQ-008 Ports: buf_full  output  1  one-deep pending-command buffer occupied.
REQ-009 Ports: cmd_sent  output  1  one-cycle pulse when a full command (both bytes) has left TX.
REQ-010 Ports: overrun  output  1  one-cycle pulse when snd_cmd is dropped.

Function
REQ-011 Each 16-bit command SHALL be sent as two 8N1 frames, cmd[15:8] first, then cmd[7:0].
REQ-012 Each frame SHALL be: start bit 0, data bits LSB first, stop bit 1.
REQ-013 Each bit SHALL be held on TX for exactly BAUD_DIV clocks, so one command occupies exactly 20*BAUD_DIV clocks.
REQ-014 The low-byte start bit SHALL follow the high-byte stop bit with no idle gap.
REQ-015 The state machine SHALL have states IDLE, HIGH_BYTE and LOW_BYTE; it SHALL use a 4-bit bit counter (0..9), a 12-bit baud counter and a 10-bit shift register.
REQ-016 Transitions: IDLE->HIGH_BYTE on launch; HIGH_BYTE->LOW_BYTE at the end of bit 9; LOW_BYTE->HIGH_BYTE at the end of bit 9 if a command is available; otherwise LOW_BYTE->IDLE.
REQ-017 snd_cmd in IDLE SHALL be accepted. The start bit SHALL appear on TX at the next clock edge, and busy SHALL rise at that same edge.
REQ-018 snd_cmd while busy with buf_full=0 SHALL copy cmd into the buffer, and buf_full SHALL rise at the next edge.
REQ-019 snd_cmd while buf_full=1 SHALL be dropped without changing any state, and overrun SHALL pulse for one cycle.
REQ-020 At the edge ending the low-byte stop bit, cmd_sent SHALL pulse high for exactly one cycle.
REQ-021 At that same edge, if buf_full=1, the buffered command SHALL launch immediately (start bit begins at that edge), buf_full SHALL clear, and busy SHALL stay high.
REQ-022 If buf_full=0 and snd_cmd is asserted in that final cycle, that cmd SHALL launch directly with no gap.
REQ-023 If buf_full=1 and snd_cmd is asserted in that final cycle, the buffered command SHALL launch, the new cmd SHALL enter the buffer, buf_full SHALL stay 1, and no overrun SHALL occur.
REQ-024 If no command is available, TX SHALL return to 1 and busy SHALL fall at that edge.
REQ-025 cmd changes while not being accepted SHALL have no effect on TX.
REQ-026 TX SHALL be driven from a flop (glitch-free).

Reset
REQ-027 While rst=1: TX=1, busy=0, buf_full=0, cmd_sent=0, overrun=0, state=IDLE, and all counters cleared.
REQ-028 rst asserted mid-frame SHALL abort immediately: TX goes high asynchronously and the buffered command is discarded.
REQ-029 No snd_cmd SHALL be accepted in the first cycle after rst deasserts if snd_cmd was held through reset; only a high level sampled after reset counts.

Verification
REQ-030 BAUD_DIV=16, cmd=16'hA55A, single snd_cmd: TX carries frame 0xA5 then 0x5A; every bit lasts 16 clocks; cmd_sent pulses once, 320 clocks after launch; busy then falls.
REQ-031 Default BAUD_DIV, with TX looped into the existing UART receiver: 16'h1234 yields received bytes 0x12 then 0x34, with rdy asserting twice.
REQ-032 BAUD_DIV=16: send 16'h00FF, then snd_cmd 16'hFF00 mid-frame: buf_full=1; 16'hFF00 starts on the edge of the first cmd_sent pulse with no idle cycle; two cmd_sent pulses total.
REQ-033 BAUD_DIV=16: busy with buf_full=1, then a third snd_cmd: overrun pulses once; the third word never appears on TX.
REQ-034 BAUD_DIV=16: snd_cmd in the final cycle of the low-byte stop bit, both with buffer empty and with buffer full: behaviour matches REQ-022 and REQ-023 exactly.
REQ-035 rst pulsed during the high byte of 16'hC3C3 with a buffered command present: TX=1, busy=0, buf_full=0 immediately; a later 16'h0001 transmits correctly.
